// File: rtl/sdrc_define.sv
// Shared SDRAM controller widths and the packed bank-queue entry layout.
package sdrc_define;

  localparam int SDR_REQ_ID_W = 4;
  localparam int REQ_BW       = 12;
  localparam int BA_W         = 2;
  localparam int ROW_W        = 13;
  localparam int COL_W        = 13;
  localparam int NUM_BANKS    = 4;

  // id + start/last/wrap/write + ba + raddr + caddr + len
  localparam int ENTRY_W = SDR_REQ_ID_W + 4 + BA_W + ROW_W + COL_W + REQ_BW;

  typedef struct packed {
    logic [SDR_REQ_ID_W-1:0] id;
    logic                    start;
    logic                    last;
    logic                    wrap;
    logic                    write;
    logic [BA_W-1:0]         ba;
    logic [ROW_W-1:0]        raddr;
    logic [COL_W-1:0]        caddr;
    logic [REQ_BW-1:0]       len;
  } req_entry_t;

endpackage

// File: rtl/sdrc_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is always visible on rd_data.
module sdrc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdrc_bank_req_q.sv
// Bank request queue: buffers req_gen chunks for xfr_ctl and tracks open rows per bank.
module sdrc_bank_req_q
  import sdrc_define::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    r2b_req,
  input  logic [SDR_REQ_ID_W-1:0] r2b_req_id,
  input  logic                    r2b_start,
  input  logic                    r2b_last,
  input  logic                    r2b_wrap,
  input  logic                    r2b_write,
  input  logic [BA_W-1:0]         r2b_ba,
  input  logic [ROW_W-1:0]        r2b_raddr,
  input  logic [COL_W-1:0]        r2b_caddr,
  input  logic [REQ_BW-1:0]       r2b_len,
  output logic                    b2r_ack,
  output logic                    b2r_arb_ok,
  output logic                    b2x_req,
  output logic [SDR_REQ_ID_W-1:0] b2x_id,
  output logic                    b2x_start,
  output logic                    b2x_last,
  output logic                    b2x_wrap,
  output logic                    b2x_write,
  output logic [BA_W-1:0]         b2x_ba,
  output logic [ROW_W-1:0]        b2x_raddr,
  output logic [COL_W-1:0]        b2x_caddr,
  output logic [REQ_BW-1:0]       b2x_len,
  output logic                    b2x_row_hit,
  input  logic                    x2b_ack,
  input  logic                    x2b_pre_all,
  output logic                    b2x_idle
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] ARB_MAX_CNT = CW'(QDEPTH - 2);

  req_entry_t         wr_entry;
  req_entry_t         head;
  logic [ENTRY_W-1:0] fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      count;
  logic               pop;

  logic [NUM_BANKS-1:0] open_valid;
  logic [ROW_W-1:0]     open_row [NUM_BANKS];

  assign wr_entry = '{id: r2b_req_id, start: r2b_start, last: r2b_last, wrap: r2b_wrap,
                      write: r2b_write, ba: r2b_ba, raddr: r2b_raddr, caddr: r2b_caddr,
                      len: r2b_len};

  // A full queue refuses the request even if the head leaves this cycle.
  assign b2r_ack    = r2b_req & ~fifo_full;
  assign b2r_arb_ok = (count <= ARB_MAX_CNT);

  sdrc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (b2r_ack),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign head      = fifo_empty ? '0 : req_entry_t'(fifo_rd);
  assign b2x_req   = ~fifo_empty;
  assign b2x_id    = head.id;
  assign b2x_start = head.start;
  assign b2x_last  = head.last;
  assign b2x_wrap  = head.wrap;
  assign b2x_write = head.write;
  assign b2x_ba    = head.ba;
  assign b2x_raddr = head.raddr;
  assign b2x_caddr = head.caddr;
  assign b2x_len   = head.len;
  assign pop       = b2x_req & x2b_ack;
  assign b2x_idle  = fifo_empty & ~r2b_req;

  assign b2x_row_hit = b2x_req & open_valid[b2x_ba] & (open_row[b2x_ba] == b2x_raddr);

  // Precharge-all closes every row, overriding an open caused by a coincident pop.
  always_ff @(posedge clk) begin
    if (!reset_n)          open_valid <= '0;
    else if (x2b_pre_all)  open_valid <= '0;
    else if (pop)          open_valid[b2x_ba] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (pop) open_row[b2x_ba] <= b2x_raddr;
  end

endmodule

// File: tb/tb_sdrc_bank_req_q.sv
// Scoreboard bench for sdrc_bank_req_q: queue model plus per-bank open-row model.
module tb_sdrc_bank_req_q;
  import sdrc_define::*;

  localparam int QDEPTH = 4;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    r2b_req;
  logic [SDR_REQ_ID_W-1:0] r2b_req_id;
  logic                    r2b_start, r2b_last, r2b_wrap, r2b_write;
  logic [BA_W-1:0]         r2b_ba;
  logic [ROW_W-1:0]        r2b_raddr;
  logic [COL_W-1:0]        r2b_caddr;
  logic [REQ_BW-1:0]       r2b_len;
  logic                    b2r_ack, b2r_arb_ok, b2x_req;
  logic [SDR_REQ_ID_W-1:0] b2x_id;
  logic                    b2x_start, b2x_last, b2x_wrap, b2x_write;
  logic [BA_W-1:0]         b2x_ba;
  logic [ROW_W-1:0]        b2x_raddr;
  logic [COL_W-1:0]        b2x_caddr;
  logic [REQ_BW-1:0]       b2x_len;
  logic                    b2x_row_hit, x2b_ack, x2b_pre_all, b2x_idle;

  int errs = 0;
  int checks = 0;

  req_entry_t       sb_q[$];
  logic [3:0]       mvalid;
  logic [ROW_W-1:0] mrow [4];

  sdrc_bank_req_q #(.QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .r2b_req(r2b_req), .r2b_req_id(r2b_req_id), .r2b_start(r2b_start), .r2b_last(r2b_last),
    .r2b_wrap(r2b_wrap), .r2b_write(r2b_write), .r2b_ba(r2b_ba), .r2b_raddr(r2b_raddr),
    .r2b_caddr(r2b_caddr), .r2b_len(r2b_len),
    .b2r_ack(b2r_ack), .b2r_arb_ok(b2r_arb_ok), .b2x_req(b2x_req),
    .b2x_id(b2x_id), .b2x_start(b2x_start), .b2x_last(b2x_last), .b2x_wrap(b2x_wrap),
    .b2x_write(b2x_write), .b2x_ba(b2x_ba), .b2x_raddr(b2x_raddr), .b2x_caddr(b2x_caddr),
    .b2x_len(b2x_len), .b2x_row_hit(b2x_row_hit),
    .x2b_ack(x2b_ack), .x2b_pre_all(x2b_pre_all), .b2x_idle(b2x_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic req_entry_t mk(input logic [1:0] ba, input logic [12:0] raddr);
    req_entry_t e;
    e.id    = 4'($urandom);
    e.start = 1'($urandom);
    e.last  = 1'($urandom);
    e.wrap  = 1'($urandom);
    e.write = 1'($urandom);
    e.ba    = ba;
    e.raddr = raddr;
    e.caddr = 13'($urandom);
    e.len   = 12'($urandom);
    return e;
  endfunction

  task automatic check_outputs(input logic req);
    int n;
    req_entry_t obs;
    n = sb_q.size();
    obs = '{id: b2x_id, start: b2x_start, last: b2x_last, wrap: b2x_wrap, write: b2x_write,
            ba: b2x_ba, raddr: b2x_raddr, caddr: b2x_caddr, len: b2x_len};
    chk("b2r_ack", b2r_ack, req && (n < QDEPTH));
    chk("b2r_arb_ok", b2r_arb_ok, (QDEPTH - n) >= 2);
    chk("b2x_req", b2x_req, n != 0);
    chk("b2x_idle", b2x_idle, (n == 0) && !req);
    chk("count", dut.u_fifo.count, n);
    if (n != 0) begin
      chk("payload", obs, sb_q[0]);
      chk("row_hit", b2x_row_hit, mvalid[sb_q[0].ba] && (mrow[sb_q[0].ba] == sb_q[0].raddr));
    end else begin
      chk("payload_empty", obs, 0);
      chk("row_hit_empty", b2x_row_hit, 0);
    end
  endtask

  task automatic tick(input logic req, input req_entry_t e, input logic ack, input logic pa);
    bit do_push, do_pop;
    req_entry_t h;
    r2b_req = req;
    {r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write, r2b_ba, r2b_raddr, r2b_caddr, r2b_len} = e;
    x2b_ack = ack;
    x2b_pre_all = pa;
    #1;
    check_outputs(req);
    do_push = req && (sb_q.size() < QDEPTH);
    do_pop  = ack && (sb_q.size() != 0);
    if (do_pop) begin
      h = sb_q.pop_front();
      mvalid[h.ba] = 1'b1;
      mrow[h.ba] = h.raddr;
    end
    if (do_push) sb_q.push_back(e);
    if (pa) mvalid = '0;
    @(posedge clk);
    #1;
    r2b_req = 1'b0;
    x2b_ack = 1'b0;
    x2b_pre_all = 1'b0;
    #1;
  endtask

  req_entry_t e;

  initial begin
    reset_n = 1'b0;
    r2b_req = 1'b0; x2b_ack = 1'b0; x2b_pre_all = 1'b0;
    {r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write, r2b_ba, r2b_raddr, r2b_caddr, r2b_len} = '0;
    mvalid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check_outputs(1'b0);
    r2b_req = 1'b1;
    #1;
    check_outputs(1'b1);
    r2b_req = 1'b0;
    #1;

    // Single push, visible next cycle, no row open yet.
    e = mk(2'd1, 13'h0123);
    e.len = 12'd8;
    tick(1'b1, e, 1'b0, 1'b0);
    chk("first_req", b2x_req, 1'b1);
    chk("first_len", b2x_len, 12'd8);
    chk("first_hit", b2x_row_hit, 1'b0);

    // Row hit after popping same row; miss on a different row.
    tick(1'b0, e, 1'b1, 1'b0);
    tick(1'b1, mk(2'd1, 13'h0123), 1'b0, 1'b0);
    chk("same_row_hit", b2x_row_hit, 1'b1);
    tick(1'b0, e, 1'b1, 1'b0);
    tick(1'b1, mk(2'd1, 13'h0124), 1'b0, 1'b0);
    chk("new_row_miss", b2x_row_hit, 1'b0);
    tick(1'b0, e, 1'b1, 1'b0);

    // Fill to full, then pop+push while full.
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, mk(2'($urandom), 13'($urandom)), 1'b0, 1'b0);
      if (i == 2) chk("arb_ok_at3", b2r_arb_ok, 1'b0);
    end
    r2b_req = 1'b1;
    #1;
    chk("ack_when_full", b2r_ack, 1'b0);
    tick(1'b1, mk(2'd3, 13'h1fff), 1'b1, 1'b0);
    chk("count_after_full_pp", dut.u_fifo.count, 3);
    repeat (3) tick(1'b0, e, 1'b1, 1'b0);

    // Steady push+pop at count 2 keeps order.
    repeat (2) tick(1'b1, mk(2'($urandom), 13'($urandom)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, mk(2'($urandom), 13'($urandom % 4)), 1'b1, 1'b0);
    chk("count_steady", dut.u_fifo.count, 2);
    repeat (2) tick(1'b0, e, 1'b1, 1'b0);

    // Open all banks, then pre_all with a pop.
    for (int b = 0; b < 4; b++) tick(1'b1, mk(2'(b), 13'(16'h0100 + b)), 1'b0, 1'b0);
    repeat (4) tick(1'b0, e, 1'b1, 1'b0);
    tick(1'b1, mk(2'd2, 13'h0102), 1'b0, 1'b0);
    tick(1'b1, mk(2'd0, 13'h0100), 1'b0, 1'b0);
    chk("pre_hit_bank2", b2x_row_hit, 1'b1);
    tick(1'b0, e, 1'b1, 1'b1);
    chk("open_valid_clr", dut.open_valid, 4'h0);
    chk("hit_after_pre", b2x_row_hit, 1'b0);
    tick(1'b0, e, 1'b1, 1'b0);

    // Reset with 3 entries queued.
    repeat (3) tick(1'b1, mk(2'($urandom), 13'($urandom)), 1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    sb_q.delete();
    mvalid = '0;
    check_outputs(1'b0);
    chk("rst_b2x_req", b2x_req, 1'b0);
    chk("rst_arb_ok", b2r_arb_ok, 1'b1);
    reset_n = 1'b1;
    #1;
    tick(1'b1, mk(2'd0, 13'h0001), 1'b0, 1'b0);
    tick(1'b0, e, 1'b1, 1'b0);
    check_outputs(1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
